// File: rtl/wieg_regelaar_if.sv
// wieg_regelaar_if -- signal bundle between the stress block, the rocking
// controller and the motor driver.
//   slow      : single-cycle slow tick enable
//   enable    : 1 = rock, 0 = stop
//   gedaald   : stress decreased since the previous measurement
//   gelijk    : stress unchanged
//   niveau    : current speed level, 0 = motor off
//   pwm       : registered motor PWM drive
//   richting  : search direction, 1 = up
//   actief    : controller is actively rocking
//   eval_puls : one-clk pulse on each evaluation
// Modport slave is the controller side, modport master the side that feeds it.
`timescale 1ns/1ps
interface wieg_regelaar_if #(
  parameter int LEVEL_W = 3
) ();
  logic               slow;
  logic               enable;
  logic               gedaald;
  logic               gelijk;
  logic [LEVEL_W-1:0] niveau;
  logic               pwm;
  logic               richting;
  logic               actief;
  logic               eval_puls;

  modport slave (
    input  slow, enable, gedaald, gelijk,
    output niveau, pwm, richting, actief, eval_puls
  );

  modport master (
    output slow, enable, gedaald, gelijk,
    input  niveau, pwm, richting, actief, eval_puls
  );
endinterface

// File: rtl/wieg_regelaar.sv
// wieg_regelaar -- closed-loop cradle rocking controller.
// Hill-climbs over speed levels using the stress-trend flags: keeps stepping
// while stress drops, holds while it is stable, reverses when it rises.
// Drives the current level plus a glitch-free PWM motor signal.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : wieg_regelaar_if.slave (slow, enable, gedaald, gelijk in;
//           niveau, pwm, richting, actief, eval_puls out)
// Optional feature: define ROCK_RAMPDOWN_EN to ramp the level down to zero
// after CALM_EVALS consecutive calm evaluations (RAMP and DONE states).
`timescale 1ns/1ps
module wieg_regelaar #(
  parameter int LEVEL_W      = 3,
  parameter int MAX_LEVEL    = 7,
  parameter int START_LEVEL  = 3,
  parameter int SETTLE_TICKS = 32,
  parameter int EVAL_TICKS   = 16,
  parameter int PWM_W        = 8,
  parameter int CALM_EVALS   = 8
) (
  input logic         clk,
  input logic         reset,
  wieg_regelaar_if.slave bus
);

  localparam int CNT_MAX = (SETTLE_TICKS > EVAL_TICKS) ? SETTLE_TICKS : EVAL_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_TICKS - 1);
  localparam logic [CNT_W-1:0]   EVAL_LAST   = CNT_W'(EVAL_TICKS - 1);
  localparam logic [LEVEL_W-1:0] LVL_ZERO    = {LEVEL_W{1'b0}};
  localparam logic [LEVEL_W-1:0] LVL_ONE     = LEVEL_W'(1);
  localparam logic [LEVEL_W-1:0] LVL_MAX     = LEVEL_W'(MAX_LEVEL);
  localparam logic [LEVEL_W-1:0] LVL_START   = LEVEL_W'(START_LEVEL);
  localparam logic [PWM_W-1:0]   PWM_ZERO    = {PWM_W{1'b0}};
  localparam logic [PWM_W-1:0]   PWM_ONE     = PWM_W'(1);
  localparam logic [PWM_W-1:0]   PWM_ONES    = {PWM_W{1'b1}};

`ifdef ROCK_RAMPDOWN_EN
  localparam int CALM_W = $clog2(CALM_EVALS + 1);
  localparam logic [CALM_W-1:0] CALM_ZERO = {CALM_W{1'b0}};
  localparam logic [CALM_W-1:0] CALM_ONE  = CALM_W'(1);
  localparam logic [CALM_W-1:0] CALM_LAST = CALM_W'(CALM_EVALS - 1);
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_RUN    = 3'd2
`ifdef ROCK_RAMPDOWN_EN
    ,
    ST_RAMP   = 3'd3,
    ST_DONE   = 3'd4
`endif
  } state_t;

  state_t             state_r, state_s;
  logic [CNT_W-1:0]   tick_r, tick_s;
  logic [LEVEL_W-1:0] niveau_r, niveau_s;
  logic               richting_r, richting_s;
  logic               eval_r, eval_s;
  logic               actief_r, actief_s;
  logic [PWM_W-1:0]   pwm_cnt_r, duty_r, duty_s;
  logic               pwm_r;
`ifdef ROCK_RAMPDOWN_EN
  logic [CALM_W-1:0]  calm_r, calm_s;
`endif

  // Evaluation decode: a rise reverses the search before stepping.
  logic rise_s, stepping_s, step_dir_s, at_bound_s, tick_hit_s, ramp_go_s;
  assign rise_s     = ~bus.gedaald & ~bus.gelijk;
  assign stepping_s = bus.gedaald | rise_s;
  assign step_dir_s = rise_s ? ~richting_r : richting_r;
  assign at_bound_s = step_dir_s ? (niveau_r >= LVL_MAX) : (niveau_r <= LVL_ONE);
  assign tick_hit_s = bus.slow &&
                      (tick_r == ((state_r == ST_SETTLE) ? SETTLE_LAST : EVAL_LAST));
`ifdef ROCK_RAMPDOWN_EN
  assign ramp_go_s  = ~rise_s & (calm_r == CALM_LAST);
  assign actief_s   = (state_s == ST_SETTLE) || (state_s == ST_RUN) || (state_s == ST_RAMP);
`else
  assign ramp_go_s  = 1'b0;
  assign actief_s   = (state_s == ST_SETTLE) || (state_s == ST_RUN);
`endif

  // Next-state, level, direction and tick-counter decisions.
  always_comb begin
    state_s    = state_r;
    niveau_s   = niveau_r;
    richting_s = richting_r;
    eval_s     = 1'b0;
    tick_s     = bus.slow ? (tick_r + CNT_ONE) : tick_r;
`ifdef ROCK_RAMPDOWN_EN
    calm_s     = calm_r;
`endif
    if (!bus.enable) begin
      state_s  = ST_IDLE;
      niveau_s = LVL_ZERO;
      tick_s   = CNT_ZERO;
`ifdef ROCK_RAMPDOWN_EN
      calm_s   = CALM_ZERO;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s    = ST_SETTLE;
          niveau_s   = LVL_START;
          richting_s = 1'b1;
          tick_s     = CNT_ZERO;
        end
        ST_SETTLE: begin
          if (tick_hit_s) begin
            state_s = ST_RUN;
            tick_s  = CNT_ZERO;
          end else begin
            state_s = ST_SETTLE;
          end
        end
        ST_RUN: begin
          if (tick_hit_s) begin
            eval_s = 1'b1;
            tick_s = CNT_ZERO;
            if (ramp_go_s) begin
`ifdef ROCK_RAMPDOWN_EN
              state_s = ST_RAMP;
              calm_s  = CALM_ZERO;
`else
              state_s = ST_RUN;
`endif
            end else if (stepping_s && !at_bound_s) begin
              niveau_s   = step_dir_s ? (niveau_r + LVL_ONE) : (niveau_r - LVL_ONE);
              richting_s = step_dir_s;
              state_s    = ST_SETTLE;
`ifdef ROCK_RAMPDOWN_EN
              calm_s     = CALM_ZERO;
`endif
            end else if (stepping_s) begin
              // Pinned at a bound: level stays, search turns around.
              richting_s = ~step_dir_s;
`ifdef ROCK_RAMPDOWN_EN
              calm_s     = rise_s ? CALM_ZERO : (calm_r + CALM_ONE);
`endif
            end else begin
              richting_s = richting_r;
`ifdef ROCK_RAMPDOWN_EN
              calm_s     = calm_r + CALM_ONE;
`endif
            end
          end else begin
            state_s = ST_RUN;
          end
        end
`ifdef ROCK_RAMPDOWN_EN
        ST_RAMP: begin
          if (tick_hit_s) begin
            eval_s = 1'b1;
            tick_s = CNT_ZERO;
            if (rise_s) begin
              state_s    = ST_SETTLE;
              niveau_s   = (niveau_r == LVL_ZERO) ? LVL_ONE : niveau_r;
              richting_s = 1'b1;
              calm_s     = CALM_ZERO;
            end else begin
              niveau_s = niveau_r - LVL_ONE;
              state_s  = (niveau_r == LVL_ONE) ? ST_DONE : ST_RAMP;
            end
          end else begin
            state_s = ST_RAMP;
          end
        end
        ST_DONE: begin
          state_s  = ST_DONE;
          niveau_s = LVL_ZERO;
          tick_s   = CNT_ZERO;
          calm_s   = CALM_ZERO;
        end
`endif
        default: begin
          state_s  = ST_IDLE;
          niveau_s = LVL_ZERO;
          tick_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // Controller state and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      tick_r     <= CNT_ZERO;
      niveau_r   <= LVL_ZERO;
      richting_r <= 1'b1;
      eval_r     <= 1'b0;
      actief_r   <= 1'b0;
`ifdef ROCK_RAMPDOWN_EN
      calm_r     <= CALM_ZERO;
`endif
    end else begin
      state_r    <= state_s;
      tick_r     <= tick_s;
      niveau_r   <= niveau_s;
      richting_r <= richting_s;
      eval_r     <= eval_s;
      actief_r   <= actief_s;
`ifdef ROCK_RAMPDOWN_EN
      calm_r     <= calm_s;
`endif
    end
  end

  assign duty_s = PWM_W'(niveau_r) << (PWM_W - LEVEL_W);

  // PWM: duty is picked up only at the counter wrap so a period is never cut
  // short; a zero level kills the output and the duty right away.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_cnt_r <= PWM_ZERO;
      duty_r    <= PWM_ZERO;
      pwm_r     <= 1'b0;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + PWM_ONE;
      if (niveau_r == LVL_ZERO) begin
        duty_r <= PWM_ZERO;
      end else if (pwm_cnt_r == PWM_ONES) begin
        duty_r <= duty_s;
      end else begin
        duty_r <= duty_r;
      end
      pwm_r <= (niveau_r != LVL_ZERO) && (pwm_cnt_r < duty_r);
    end
  end

  assign bus.niveau    = niveau_r;
  assign bus.pwm       = pwm_r;
  assign bus.richting  = richting_r;
  assign bus.actief    = actief_r;
  assign bus.eval_puls = eval_r;

endmodule

// File: tb/tb_wieg_regelaar.sv
`timescale 1ns/1ps
module tb_wieg_regelaar;
  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_seen;
  int   highs;

  wieg_regelaar_if #(.LEVEL_W(3)) bus_if ();

  wieg_regelaar #(
    .LEVEL_W(3), .MAX_LEVEL(7), .START_LEVEL(3), .SETTLE_TICKS(32),
    .EVAL_TICKS(16), .PWM_W(8), .CALM_EVALS(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // Directed hill-climb steps: flags applied before the evaluation, clocks
  // until that eval_puls, and the level/direction expected right after it.
  int t_gd  [22] = '{1,1,1,1,1,1,1,1,1,0,0,1,0,0,1,1,1,1,1,1,1,1};
  int t_gl  [22] = '{0,0,0,0,0,0,0,0,0,0,0,1,1,1,0,0,0,0,0,0,0,0};
  int t_n   [22] = '{47,47,48,48,48,16,48,48,48,48,48,48,48,16,16,48,16,48,48,48,48,48};
  int t_niv [22] = '{4,5,6,7,7,6,5,4,3,4,3,2,2,2,1,1,2,3,4,5,6,7};
  int t_dir [22] = '{1,1,1,1,0,0,0,0,0,1,0,0,0,0,0,1,1,1,1,1,1,1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_eval(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while ((bus_if.eval_puls !== 1'b1) && (n < 300));
  endtask

  // Aligns on a pwm rising edge, then counts high clocks over one period.
  // With poke set, a rise evaluation is provoked early in that period.
  task automatic measure_period(input bit poke, output int hi);
    int   guard;
    logic prev;
    guard = 0;
    do begin
      prev = bus_if.pwm;
      step(1);
      guard++;
    end while (!((prev === 1'b0) && (bus_if.pwm === 1'b1)) && (guard < 600));
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      if (poke && (i == 20)) begin
        bus_if.gedaald = 1'b0;
        bus_if.gelijk  = 1'b0;
      end
      if (poke && (i == 60)) begin
        bus_if.gelijk = 1'b1;
      end
      if (bus_if.pwm === 1'b1) hi++;
      step(1);
    end
  endtask

  initial begin
    reset          = 1'b0;
    bus_if.slow    = 1'b1;
    bus_if.enable  = 1'b1;
    bus_if.gedaald = 1'b1;
    bus_if.gelijk  = 1'b0;
    step(3);
    chk("rst_niveau",   bus_if.niveau,    0);
    chk("rst_pwm",      bus_if.pwm,       0);
    chk("rst_richting", bus_if.richting,  1);
    chk("rst_actief",   bus_if.actief,    0);
    chk("rst_eval",     bus_if.eval_puls, 0);

    reset = 1'b1;
    step(2);
    chk("start_niveau",   bus_if.niveau,   3);
    chk("start_actief",   bus_if.actief,   1);
    chk("start_richting", bus_if.richting, 1);

    // First eval lands 1 + 32 + 16 clocks after release (slow every clk).
    for (int k = 0; k < 22; k++) begin
      bus_if.gedaald = t_gd[k][0];
      bus_if.gelijk  = t_gl[k][0];
      wait_eval(n_seen);
      chk($sformatf("step%0d_interval", k + 1), n_seen, t_n[k]);
      chk($sformatf("step%0d_niveau", k + 1), bus_if.niveau, t_niv[k]);
      chk($sformatf("step%0d_richting", k + 1), bus_if.richting, t_dir[k]);
      if (k == 0) begin
        step(1);
        chk("eval_width", bus_if.eval_puls, 0);
      end
    end

    // Hold at level 7: 224 of 256 clocks high once the duty is latched.
    bus_if.gedaald = 1'b0;
    bus_if.gelijk  = 1'b1;
    step(600);
    measure_period(1'b0, highs);
    chk("pwm_lvl7", highs, 224);
    measure_period(1'b1, highs);
    chk("pwm_midchange", highs, 224);
    chk("mid_niveau",   bus_if.niveau,   6);
    chk("mid_richting", bus_if.richting, 0);
    measure_period(1'b0, highs);
    chk("pwm_lvl6", highs, 192);

    bus_if.enable = 1'b0;
    step(1);
    chk("off_niveau", bus_if.niveau, 0);
    chk("off_actief", bus_if.actief, 0);
    step(1);
    chk("off_pwm", bus_if.pwm, 0);
    highs = 0;
    for (int i = 0; i < 300; i++) begin
      if (bus_if.pwm === 1'b1) highs++;
      step(1);
    end
    chk("off_pwm_quiet", highs, 0);

    bus_if.enable = 1'b1;
    step(1);
    chk("restart_niveau",   bus_if.niveau,   3);
    chk("restart_actief",   bus_if.actief,   1);
    chk("restart_richting", bus_if.richting, 1);

    // Reset mid-cycle must clear outputs without waiting for a clock edge.
    #2;
    reset = 1'b0;
    #1;
    chk("async_niveau", bus_if.niveau, 0);
    chk("async_actief", bus_if.actief, 0);
    chk("async_pwm",    bus_if.pwm,    0);
    step(2);

`ifdef ROCK_RAMPDOWN_EN
    bus_if.gedaald = 1'b0;
    bus_if.gelijk  = 1'b1;
    reset = 1'b1;
    step(2);
    for (int k = 0; k < 8; k++) begin
      wait_eval(n_seen);
      chk($sformatf("calm%0d_interval", k + 1), n_seen, (k == 0) ? 47 : 16);
      chk($sformatf("calm%0d_niveau", k + 1), bus_if.niveau, 3);
    end
    chk("ramp_actief", bus_if.actief, 1);
    for (int k = 0; k < 3; k++) begin
      wait_eval(n_seen);
      chk($sformatf("ramp%0d_interval", k + 1), n_seen, 16);
      chk($sformatf("ramp%0d_niveau", k + 1), bus_if.niveau, 2 - k);
    end
    chk("done_actief", bus_if.actief, 0);
    step(2);
    chk("done_pwm", bus_if.pwm, 0);
    bus_if.enable = 1'b0;
    step(2);
    bus_if.enable = 1'b1;
    step(2);
    chk("ramp_restart_niveau", bus_if.niveau, 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/wieg_regelaar.md
Name: wieg_regelaar

Overview:
- Closed-loop rocking controller; consumes the stress-trend flags (gedaald, gelijk) produced by the stress block and drives the cradle motor.
- Runs a hill-climbing search over rocking speed levels: keeps stepping while stress drops, holds while it is stable, reverses when it rises.
- Outputs the current speed level plus a PWM motor drive; sits between the stress block and the motor driver, clocked by the shared clk and slow tick.

Parameters:
- LEVEL_W, 3, width of speed level.
- MAX_LEVEL, 7, highest speed level (must be < 2^LEVEL_W).
- START_LEVEL, 3, level loaded on start (1..MAX_LEVEL).
- SETTLE_TICKS, 32, slow ticks to wait after any level change before evaluating.
- EVAL_TICKS, 16, slow ticks between evaluations in RUN.
- PWM_W, 8, PWM counter width (PWM_W >= LEVEL_W).
- CALM_EVALS, 8, consecutive calm evaluations before ramp-down (optional feature only).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- slow  in  1  single-cycle tick enable (same slow tick as the stress block).
- enable  in  1  level: 1 = rock, 0 = stop.
- gedaald  in  1  stress decreased since last measurement.
- gelijk  in  1  stress unchanged.
- niveau  out  LEVEL_W  current speed level, 0 = motor off.
- pwm  out  1  motor PWM drive, registered.
- richting  out  1  search direction, 1 = up.
- actief  out  1  high in SETTLE/RUN (and RAMP).
- eval_puls  out  1  one-clk pulse on each evaluation.

Behaviour:
- Reset (async, reset=0):
  - state IDLE; niveau=0, pwm=0, richting=1, actief=0, eval_puls=0.
  - All counters cleared.
- Reset mid-operation: immediate return to the reset values; no ramp.
- Tick counter: counts slow ticks only; cleared on every state entry.
- IDLE:
  - niveau=0.
  - enable=1 -> SETTLE next clk; niveau<=START_LEVEL, richting<=1.
- SETTLE: on the slow tick where the count reaches SETTLE_TICKS -> RUN.
- RUN: on the slow tick where the count reaches EVAL_TICKS, evaluate that cycle and pulse eval_puls for 1 clk.
  - Flags sampled in that cycle; gedaald has priority over gelijk.
  - gedaald=1: step one level in richting.
  - gelijk=1 only: hold; counter cleared; stay in RUN.
  - Both 0 (stress rose): toggle richting, then step one level in the new direction.
  - Step clamps to 1..MAX_LEVEL. At a bound, niveau is unchanged, richting flips, and the block stays in RUN.
  - niveau changed -> SETTLE. Unchanged -> stay in RUN with counter cleared.
- enable=0 in any state: IDLE on the next clk; niveau=0, actief=0.
- PWM:
  - Free-running PWM_W-bit counter, increments every clk.
  - duty = niveau << (PWM_W-LEVEL_W). duty is latched only when the counter = all-ones, so no mid-period glitches.
  - pwm <= (cnt < duty_latched), registered (1-clk latency). niveau=0 gives pwm constantly 0.

Optional Feature:
- Macro: ROCK_RAMPDOWN_EN.
- Defined:
  - A calm counter increments on each evaluation with gedaald or gelijk, and clears on a rise evaluation or when leaving RUN/RAMP.
  - At CALM_EVALS calm evaluations in a row -> RAMP.
  - RAMP: niveau decrements by 1 every EVAL_TICKS slow ticks; eval_puls still fires.
  - A rise evaluation in RAMP -> SETTLE at max(niveau,1) with richting=1 and the calm counter cleared.
  - niveau reaching 0 -> DONE: actief=0, pwm=0. DONE is left only via enable=0 (-> IDLE).
- Undefined: no calm counter, no RAMP/DONE states; RUN continues indefinitely.

Test Plan:
- Reset with enable=1 and slow every clk: after reset release, niveau=3 from the 2nd clk, actief=1, first eval_puls exactly 32+16 slow ticks later.
- gedaald held 1 at each evaluation from niveau=3: niveau 4,5,6,7. Next evaluation: niveau stays 7, richting=0. Following evaluation: niveau=6.
- gedaald=0, gelijk=0 at evaluation with niveau=4, richting=1: richting=0, niveau=3, state SETTLE (next eval_puls after 32+16 ticks).
- gelijk=1, gedaald=1 simultaneously: treated as gedaald, niveau steps. gelijk only: niveau unchanged, next eval after 16 ticks.
- PWM: niveau=7, PWM_W=8 -> pwm high 224 of every 256 clks once aligned. Change niveau mid-period -> duty changes only at the next counter wrap. enable=0 -> niveau=0, pwm=0 within 2 clks.
- ROCK_RAMPDOWN_EN with CALM_EVALS=8, gelijk held 1 at niveau=3: RAMP after the 8th eval, niveau 2,1,0 on successive evals, then actief=0; toggling enable 0->1 restarts at niveau=3.
